// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : wb_arb_pkg
// Brief    : Shared widths, x0 constant and arbiter FSM state encoding.
//            WB_ARB_STARVE_EN adds the FORCE state.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package wb_arb_pkg;

  localparam int c_REG_AW = 5;
  localparam int c_DATA_W = 32;
  localparam logic [c_REG_AW-1:0] c_X0 = '0;

`ifdef WB_ARB_STARVE_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } wb_arb_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1
  } wb_arb_state_t;
`endif

endpackage
`default_nettype wire

// File: rtl/wb_arb_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : wb_arb_fifo
// Brief    : Power-of-two FIFO for long-latency results, with per-entry
//            valid bits and address-compare vectors for hazard detection.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_push,
  input  logic [c_REG_AW-1:0] i_wa,
  input  logic [c_DATA_W-1:0] i_wd,
  input  logic                i_pop,
  input  logic [c_REG_AW-1:0] i_cmp_a,
  input  logic [c_REG_AW-1:0] i_cmp_b,
  output logic                o_full,
  output logic                o_empty,
  output logic                o_empty_nxt,
  output logic [c_REG_AW-1:0] o_head_wa,
  output logic [c_DATA_W-1:0] o_head_wd,
  output logic [DEPTH-1:0]    o_hit_a,
  output logic [DEPTH-1:0]    o_hit_b
);

  localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CW = c_PW + 1;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

  logic [c_PW-1:0]     r_wr_ptr;
  logic [c_PW-1:0]     r_rd_ptr;
  logic [c_CW-1:0]     r_cnt;
  logic [c_CW-1:0]     w_cnt_nxt;
  logic [DEPTH-1:0]    r_vld;
  logic [c_REG_AW-1:0] r_wa [DEPTH];
  logic [c_DATA_W-1:0] r_wd [DEPTH];
  logic                w_do_push;
  logic                w_do_pop;

  assign o_full    = (r_cnt == c_FULL);
  assign o_empty   = (r_cnt == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_do_push && !w_do_pop) begin
      w_cnt_nxt = r_cnt + c_CW'(1);
    end else if (w_do_pop && !w_do_push) begin
      w_cnt_nxt = r_cnt - c_CW'(1);
    end
  end

  assign o_empty_nxt = (w_cnt_nxt == '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_vld    <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_do_pop) begin
        r_rd_ptr        <= r_rd_ptr + c_PW'(1);
        r_vld[r_rd_ptr] <= 1'b0;
      end
      if (w_do_push) begin
        r_wr_ptr        <= r_wr_ptr + c_PW'(1);
        r_vld[r_wr_ptr] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_wa[r_wr_ptr] <= i_wa;
      r_wd[r_wr_ptr] <= i_wd;
    end
  end

  assign o_head_wa = r_wa[r_rd_ptr];
  assign o_head_wd = r_wd[r_rd_ptr];

  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign o_hit_a[i] = r_vld[i] && (r_wa[i] == i_cmp_a);
    assign o_hit_b[i] = r_vld[i] && (r_wa[i] == i_cmp_b);
  end

endmodule
`default_nettype wire

// File: rtl/wb_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : wb_arb
// Brief    : Register-file write-port arbiter: pipeline writeback first,
//            buffered long-latency results drain in idle slots.
//            WB_ARB_STARVE_EN enables the starvation guard (STALL_REQ).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module wb_arb
  import wb_arb_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                WEN_W,
  input  logic [c_REG_AW-1:0] WA_W,
  input  logic [c_DATA_W-1:0] WD_W,
  input  logic                LL_VALID,
  input  logic [c_REG_AW-1:0] LL_WA,
  input  logic [c_DATA_W-1:0] LL_WD,
  output logic                LL_READY,
  input  logic [c_REG_AW-1:0] RA1,
  input  logic [c_REG_AW-1:0] RA2,
  output logic                PEND_HIT,
  output logic                STALL_REQ,
  output logic                RF_WEN,
  output logic [c_REG_AW-1:0] RF_WA,
  output logic [c_DATA_W-1:0] RF_WD
);

  logic                  w_pipe_act;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_empty_nxt;
  logic                  w_push;
  logic                  w_pop;
  logic [c_REG_AW-1:0]   w_head_wa;
  logic [c_DATA_W-1:0]   w_head_wd;
  logic [FIFO_DEPTH-1:0] w_hit_a;
  logic [FIFO_DEPTH-1:0] w_hit_b;
  wb_arb_state_t         r_state;
  wb_arb_state_t         w_state_nxt;

  assign w_pipe_act = !WEN_W && (WA_W != c_X0);
  // Outputs are qualified with RSTN so they read idle during an async reset.
  assign LL_READY   = RSTN && !w_full;
  // x0 results are accepted but never stored.
  assign w_push     = LL_VALID && LL_READY && (LL_WA != c_X0);
  assign w_pop      = RSTN && !w_pipe_act && !w_empty;

  wb_arb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (CLK),
    .rst_n       (RSTN),
    .i_push      (w_push),
    .i_wa        (LL_WA),
    .i_wd        (LL_WD),
    .i_pop       (w_pop),
    .i_cmp_a     (RA1),
    .i_cmp_b     (RA2),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_empty_nxt (w_empty_nxt),
    .o_head_wa   (w_head_wa),
    .o_head_wd   (w_head_wd),
    .o_hit_a     (w_hit_a),
    .o_hit_b     (w_hit_b)
  );

  always_comb begin
    RF_WEN = 1'b1;
    RF_WA  = c_X0;
    RF_WD  = '0;
    if (RSTN) begin
      if (w_pipe_act) begin
        RF_WEN = 1'b0;
        RF_WA  = WA_W;
        RF_WD  = WD_W;
      end else if (!w_empty) begin
        RF_WEN = 1'b0;
        RF_WA  = w_head_wa;
        RF_WD  = w_head_wd;
      end
    end
  end

  assign PEND_HIT = RSTN && (((RA1 != c_X0) && (|w_hit_a)) ||
                             ((RA2 != c_X0) && (|w_hit_b)));

`ifdef WB_ARB_STARVE_EN
  localparam int c_SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_SW-1:0] c_LIMIT = c_SW'(STARVE_LIMIT);

  logic [c_SW-1:0] r_starve;
  logic [c_SW-1:0] w_starve_nxt;

  // Counts cycles the buffered head is denied the port by the pipeline.
  always_comb begin
    w_starve_nxt = r_starve;
    if (w_pop || w_empty) begin
      w_starve_nxt = '0;
    end else if (w_pipe_act && (r_starve != c_LIMIT)) begin
      w_starve_nxt = r_starve + c_SW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_starve <= '0;
    end else begin
      r_starve <= w_starve_nxt;
    end
  end

  assign STALL_REQ = (r_state == ST_FORCE);
`else
  assign STALL_REQ = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty_nxt) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_empty_nxt) begin
          w_state_nxt = ST_IDLE;
`ifdef WB_ARB_STARVE_EN
        end else if (w_starve_nxt >= c_LIMIT) begin
          w_state_nxt = ST_FORCE;
`endif
        end
      end
`ifdef WB_ARB_STARVE_EN
      ST_FORCE: begin
        if (w_pop) begin
          w_state_nxt = w_empty_nxt ? ST_IDLE : ST_WAIT;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_arb.sv
`default_nettype none
// Scoreboard bench for wb_arb: expected port writes are queued in order and
// a negedge monitor checks every RF_WEN=0 cycle against the queue head.
module tb_wb_arb;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        WEN_W;
  logic [4:0]  WA_W;
  logic [31:0] WD_W;
  logic        LL_VALID;
  logic [4:0]  LL_WA;
  logic [31:0] LL_WD;
  logic        LL_READY;
  logic [4:0]  RA1;
  logic [4:0]  RA2;
  logic        PEND_HIT;
  logic        STALL_REQ;
  logic        RF_WEN;
  logic [4:0]  RF_WA;
  logic [31:0] RF_WD;

  always #5 CLK = ~CLK;

  wb_arb #(
    .FIFO_DEPTH   (2),
    .STARVE_LIMIT (4)
  ) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .WEN_W     (WEN_W),
    .WA_W      (WA_W),
    .WD_W      (WD_W),
    .LL_VALID  (LL_VALID),
    .LL_WA     (LL_WA),
    .LL_WD     (LL_WD),
    .LL_READY  (LL_READY),
    .RA1       (RA1),
    .RA2       (RA2),
    .PEND_HIT  (PEND_HIT),
    .STALL_REQ (STALL_REQ),
    .RF_WEN    (RF_WEN),
    .RF_WA     (RF_WA),
    .RF_WD     (RF_WD)
  );

  typedef struct packed {
    logic [4:0]  wa;
    logic [31:0] wd;
  } wr_t;

  wr_t exp_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  task automatic chk1(input string name, input logic act, input logic req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic exp_wr(input logic [4:0] wa, input logic [31:0] wd);
    wr_t e;
    e.wa = wa;
    e.wd = wd;
    exp_q.push_back(e);
  endtask

  task automatic pipe(input logic wen, input logic [4:0] wa, input logic [31:0] wd);
    WEN_W = wen;
    WA_W  = wa;
    WD_W  = wd;
  endtask

  task automatic ll(input logic v, input logic [4:0] wa, input logic [31:0] wd);
    LL_VALID = v;
    LL_WA    = wa;
    LL_WD    = wd;
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin : monitor
    wr_t e;
    if (RSTN === 1'b1 && RF_WEN === 1'b0) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL port_write: got wa=%0d wd=0x%08h, required no write", RF_WA, RF_WD);
      end else begin
        e = exp_q.pop_front();
        if (RF_WA !== e.wa || RF_WD !== e.wd) begin
          n_fail++;
          $display("FAIL port_write: got wa=%0d wd=0x%08h, required wa=%0d wd=0x%08h",
                   RF_WA, RF_WD, e.wa, e.wd);
        end
      end
    end
  end

  logic [8:0] rdy_tab;
  logic [8:0] stall_tab;
  logic [8:0] pend_tab;

  initial begin
    rdy_tab = 9'b110000011;
`ifdef WB_ARB_STARVE_EN
    stall_tab = 9'b001100000;
`else
    stall_tab = 9'b000000000;
`endif
    pend_tab = 9'b000010110;

    // Reset with an active pipeline write and a pending LL result.
    RSTN = 1'b0;
    pipe(1'b0, 5'd3, 32'h1);
    ll(1'b1, 5'd7, 32'h2);
    RA1 = 5'd7;
    RA2 = 5'd0;
    repeat (2) nxt();
    @(negedge CLK);
    chk1("rst_rf_wen", RF_WEN, 1'b1);
    chk32("rst_rf_wa", {27'b0, RF_WA}, 32'h0);
    chk32("rst_rf_wd", RF_WD, 32'h0);
    chk1("rst_ll_ready", LL_READY, 1'b0);
    chk1("rst_stall", STALL_REQ, 1'b0);
    chk1("rst_pend", PEND_HIT, 1'b0);
    nxt();
    pipe(1'b1, 5'd0, 32'h0);
    ll(1'b0, 5'd0, 32'h0);
    RA1  = 5'd0;
    RSTN = 1'b1;
    @(negedge CLK);
    chk1("rel_ll_ready", LL_READY, 1'b1);
    chk1("rel_rf_wen", RF_WEN, 1'b1);

    // Idle drain: one-cycle latency, no same-cycle pass-through.
    nxt();
    ll(1'b1, 5'd7, 32'hDEADBEEF);
    exp_wr(5'd7, 32'hDEADBEEF);
    @(negedge CLK);
    chk1("drain_ready", LL_READY, 1'b1);
    chk1("drain_no_passthru", RF_WEN, 1'b1);
    nxt();
    ll(1'b0, 5'd0, 32'h0);
    @(negedge CLK);
    chk1("drain_write", RF_WEN, 1'b0);
    nxt();
    @(negedge CLK);
    chk1("drain_done", RF_WEN, 1'b1);

    // Priority, full FIFO, starvation and push-while-full-draining.
    for (int c = 0; c < 9; c++) begin
      nxt();
      if (c < 6) begin
        pipe(1'b0, 5'd3, 32'h300 + 32'(c));
        exp_wr(5'd3, 32'h300 + 32'(c));
      end else begin
        pipe(1'b1, 5'd0, 32'h0);
      end
      if (c == 5) begin
        exp_wr(5'd10, 32'hA0);
        exp_wr(5'd11, 32'hA1);
        exp_wr(5'd12, 32'hA2);
      end
      if (c < 2)       ll(1'b1, 5'd10 + 5'(c), 32'hA0 + 32'(c));
      else if (c <= 7) ll(1'b1, 5'd12, 32'hA2);
      else             ll(1'b0, 5'd0, 32'h0);
      @(negedge CLK);
      chk1($sformatf("prio_ready_c%0d", c), LL_READY, rdy_tab[c]);
      chk1($sformatf("prio_stall_c%0d", c), STALL_REQ, stall_tab[c]);
    end
    nxt();
    ll(1'b0, 5'd0, 32'h0);
    @(negedge CLK);
    chk1("prio_empty", RF_WEN, 1'b1);

    // Hazard detection and x0 handling.
    exp_wr(5'd9, 32'h900);
    exp_wr(5'd9, 32'h901);
    exp_wr(5'd9, 32'h902);
    exp_wr(5'd9, 32'h903);
    exp_wr(5'd5, 32'h55);
    for (int c = 0; c < 9; c++) begin
      nxt();
      ll(1'b0, 5'd0, 32'h0);
      if (c < 4)       pipe(1'b0, 5'd9, 32'h900 + 32'(c));
      else if (c == 4) pipe(1'b0, 5'd0, 32'h999);
      else             pipe(1'b1, 5'd0, 32'h0);
      if (c == 0) ll(1'b1, 5'd5, 32'h55);
      if (c == 6) ll(1'b1, 5'd0, 32'h77);
      RA1 = (c == 0 || c == 1 || c == 4 || c == 5) ? 5'd5 : 5'd0;
      RA2 = (c == 2) ? 5'd5 : 5'd0;
      @(negedge CLK);
      chk1($sformatf("hz_pend_c%0d", c), PEND_HIT, pend_tab[c]);
      if (c == 6) chk1("x0_ready", LL_READY, 1'b1);
      if (c == 4) chk1("hz_stall", STALL_REQ, 1'b0);
    end

    // Reset with two results buffered behind pipeline writes.
    nxt();
    pipe(1'b0, 5'd4, 32'h400);
    ll(1'b1, 5'd20, 32'h20);
    exp_wr(5'd4, 32'h400);
    nxt();
    pipe(1'b0, 5'd4, 32'h401);
    ll(1'b1, 5'd21, 32'h21);
    exp_wr(5'd4, 32'h401);
    @(negedge CLK);
    chk1("mr_ready_1", LL_READY, 1'b1);
    nxt();
    pipe(1'b0, 5'd4, 32'h402);
    ll(1'b0, 5'd0, 32'h0);
    RA1 = 5'd20;
    RA2 = 5'd21;
    #1;
    chk1("mr_full", LL_READY, 1'b0);
    chk1("mr_pend", PEND_HIT, 1'b1);
    RSTN = 1'b0;
    #1;
    chk1("mr_rf_wen", RF_WEN, 1'b1);
    chk1("mr_ll_ready", LL_READY, 1'b0);
    chk1("mr_pend_rst", PEND_HIT, 1'b0);
    nxt();
    pipe(1'b1, 5'd0, 32'h0);
    RSTN = 1'b1;
    @(negedge CLK);
    chk1("mr_rel_ready", LL_READY, 1'b1);
    chk1("mr_rel_pend", PEND_HIT, 1'b0);
    chk1("mr_rel_rf_wen", RF_WEN, 1'b1);
    nxt();
    @(negedge CLK);
    chk1("mr_no_drain", RF_WEN, 1'b1);

    nxt();
    chk32("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
